// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a data and a control payload between pipeline stages.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 2
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if,
  output logic [1:0]        occupancy,
  input  logic              stats_clr,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
);

  // The state encoding doubles as the held-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              main_valid;
  logic              skid_valid;
  logic              acc;
  logic              drn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    acc         = in_if.valid & in_if.ready;
    drn         = main_valid & out_if.ready;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_data_d = in_if.data;
          main_ctrl_d = in_if.ctrl;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (acc && drn) begin
          main_data_d = in_if.data;
          main_ctrl_d = in_if.ctrl;
        end else if (acc) begin
          skid_data_d = in_if.data;
          skid_ctrl_d = in_if.ctrl;
          state_d     = FULL;
        end else if (drn) begin
          main_ctrl_d = '0;
          state_d     = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_ctrl_d = '0;
          state_d     = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // An item accepted alongside flush completes upstream but is dropped here.
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end
  end

  always_comb begin
    main_valid   = (state_q != EMPTY);
    skid_valid   = (state_q == FULL);
    in_if.ready  = !skid_valid;
    out_if.valid = main_valid;
    out_if.data  = main_data_q;
    out_if.ctrl  = main_ctrl_q & {CTRL_W{main_valid}};
    occupancy    = state_q;
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_q, stall_d;
  logic [STAT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (stats_clr) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (main_valid && !out_if.ready && (stall_q != '1)) stall_d = stall_q + STAT_W'(1);
      if (!main_valid && (bubble_q != '1)) bubble_d = bubble_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  logic stats_clr_unused;
  assign stats_clr_unused = stats_clr;
  assign stall_cnt        = '0;
  assign bubble_cnt       = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomised checks of pipe_stage_skid against a FIFO scoreboard.
// Build with PIPE_STAGE_STATS_EN defined to also exercise the counters (STAT_W=4).
module tb_pipe_stage_skid;
  localparam int unsigned DW = 69;
  localparam int unsigned CW = 2;
`ifdef PIPE_STAGE_STATS_EN
  localparam int unsigned SW = 4;
`else
  localparam int unsigned SW = 16;
`endif
  localparam int unsigned SAT = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          stats_clr;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] bubble_cnt;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .STAT_W(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_if      (up_if),
    .out_if     (dn_if),
    .occupancy  (occupancy),
    .stats_clr  (stats_clr),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int unsigned         checks = 0;
  int unsigned         errors = 0;
  logic [DW+CW-1:0]    sb[$];
  int unsigned         exp_stall = 0;
  int unsigned         exp_bubble = 0;

  function automatic logic [DW-1:0] mk(input int unsigned v);
    logic [31:0] w;
    w  = v;
    mk = {w[4:0], w ^ 32'hA5A5_0000, w};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int unsigned v, input logic [CW-1:0] c);
    up_if.valid = 1'b1;
    up_if.data  = mk(v);
    up_if.ctrl  = c;
  endtask

  task automatic idle(input int unsigned junk);
    up_if.valid = 1'b0;
    up_if.data  = mk(junk);
    up_if.ctrl  = 2'b11;
  endtask

  // One clock: score the handshake before the edge, then check state after it.
  task automatic tick();
    logic             acc, drn, zero_exp;
    logic [DW+CW-1:0] e;
    #1;
    acc      = up_if.valid & up_if.ready;
    drn      = dn_if.valid & dn_if.ready;
    zero_exp = rst | flush;
    if (!rst && drn === 1'b1) begin
      check("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("drn_data", dn_if.data, e[DW-1:0]);
        check("drn_ctrl", dn_if.ctrl, e[DW+CW-1:DW]);
      end
    end
    if (rst || flush) sb.delete();
    else if (acc === 1'b1) sb.push_back({up_if.ctrl, up_if.data});
    if (rst || stats_clr) begin
      exp_stall  = 0;
      exp_bubble = 0;
    end else begin
      if (dn_if.valid && !dn_if.ready && exp_stall < SAT) exp_stall++;
      if (!dn_if.valid && exp_bubble < SAT) exp_bubble++;
    end
    @(posedge clk);
    @(negedge clk);
    check("occupancy", occupancy, sb.size());
    check("out_valid", dn_if.valid, sb.size() != 0);
    check("in_ready", up_if.ready, sb.size() < 2);
    if (!dn_if.valid) check("bubble_ctrl", dn_if.ctrl, '0);
    if (sb.size() != 0) begin
      check("front_data", dn_if.data, sb[0][DW-1:0]);
      check("front_ctrl", dn_if.ctrl, sb[0][DW+CW-1:DW]);
    end
    if (zero_exp) check("cleared_data", dn_if.data, '0);
`ifdef PIPE_STAGE_STATS_EN
    check("stall_cnt", stall_cnt, exp_stall);
    check("bubble_cnt", bubble_cnt, exp_bubble);
`else
    check("stall_cnt_tied", stall_cnt, '0);
    check("bubble_cnt_tied", bubble_cnt, '0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    stats_clr    = 1'b0;
    dn_if.ready  = 1'b0;
    send(32'h99, 2'b11);
    @(negedge clk);

    // Reset held two cycles with in_valid high
    tick();
    tick();
    check("rst_out_valid", dn_if.valid, 1'b0);
    check("rst_in_ready", up_if.ready, 1'b1);
    check("rst_occ", occupancy, 2'd0);
    rst = 1'b0;
    idle(0);
    tick();

    // Streaming 1..8 with out_ready high
    dn_if.ready = 1'b1;
    for (int unsigned i = 1; i <= 8; i++) begin
      send(i, 2'b11);
      tick();
      check("stream_in_ready", up_if.ready, 1'b1);
    end
    idle(32'h77);
    tick();
    tick();

    // Skid fill: A then B while stalled
    dn_if.ready = 1'b0;
    send(32'hA, 2'b01);
    tick();
    send(32'hB, 2'b10);
    tick();
    idle(32'h55);
    tick();
    tick();
    check("skid_occ", occupancy, 2'd2);
    check("skid_in_ready", up_if.ready, 1'b0);
    check("skid_hold_data", dn_if.data, mk(32'hA));
    dn_if.ready = 1'b1;
    tick();
    check("skid_occ_1", occupancy, 2'd1);
    tick();
    check("skid_occ_0", occupancy, 2'd0);

    // Flush while FULL
    dn_if.ready = 1'b0;
    send(32'h1A, 2'b11);
    tick();
    send(32'h1B, 2'b11);
    tick();
    idle(0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_full_valid", dn_if.valid, 1'b0);
    check("flush_full_occ", occupancy, 2'd0);

    // Flush in the same cycle as accepting 0xC
    send(32'hC, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle(0);
    check("flush_acc_valid", dn_if.valid, 1'b0);
    check("flush_acc_ctrl", dn_if.ctrl, '0);
    dn_if.ready = 1'b1;
    tick();
    tick();

    // Flush with a drain in the same cycle still delivers the item
    send(32'h2D, 2'b10);
    tick();
    idle(0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Bubble ctrl after ctrl=11, then rst mid-FULL
    send(32'h3E, 2'b11);
    tick();
    idle(0);
    tick();
    tick();
    dn_if.ready = 1'b0;
    send(32'h4F, 2'b11);
    tick();
    send(32'h50, 2'b11);
    tick();
    idle(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_occ", occupancy, 2'd0);
    check("rst_mid_valid", dn_if.valid, 1'b0);

`ifdef PIPE_STAGE_STATS_EN
    // Counter saturation and clear
    send(32'h61, 2'b01);
    tick();
    idle(0);
    for (int unsigned i = 0; i < 20; i++) tick();
    check("stall_sat", stall_cnt, 4'd15);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("clr_stall", stall_cnt, '0);
    check("clr_bubble", bubble_cnt, '0);
    dn_if.ready = 1'b1;
    tick();
`endif

    // Randomised traffic with occasional flush
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) send($urandom, CW'($urandom_range(0, 3)));
      else idle($urandom);
      dn_if.ready = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      stats_clr   = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush     = 1'b0;
    stats_clr = 1'b0;
    idle(0);
    dn_if.ready = 1'b1;
    tick();
    tick();
    tick();
    check("final_empty", occupancy, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
